// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU: 8 single-cycle ops plus optional shift-add MUL (ALU_MUL_EN).
// Latency: 1 cycle for single-cycle/illegal ops, WIDTH+1 cycles (or more) for MUL.
// Backpressure: results held stable while out_valid && !out_ready; in_ready drops until the output is free.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Out_Hi,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             Err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
  logic             ovf_q, ovf_d, err_q, err_d;

  logic             out_free, accept, is_mul, mul_done;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] s_res;
  logic             s_carry, s_ovf, s_err;

  assign out_free = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath; MUL is routed to the FSM and shows up here as "illegal" only if disabled.
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    s_res   = '0;
    s_carry = 1'b0;
    s_ovf   = 1'b0;
    s_err   = 1'b0;
    case (in_op)
      OP_ADD: begin
        s_res   = sum[WIDTH-1:0];
        s_carry = sum[WIDTH];
        s_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_res   = diff[WIDTH-1:0];
        s_carry = diff[WIDTH];
        s_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  s_res = A & B;
      OP_OR:   s_res = A | B;
      OP_XOR:  s_res = A ^ B;
      OP_XNOR: s_res = ~(A ^ B);
      OP_NAND: s_res = ~(A & B);
      OP_NOR:  s_res = ~(A | B);
      default: s_err = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int         CW     = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d, hi_q, hi_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  assign is_mul     = (in_op == OP_MUL);
  assign in_ready   = !reset && (state_q == IDLE) && out_free;
  assign mul_done   = (state_q == HOLD) && out_free;
  assign ALU_Out_Hi = hi_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          state_d  = MUL;
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = HOLD;
        else                         cnt_d   = cnt_q + CW'(1);
      end
      HOLD:    if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept && !is_mul) hi_d = '0;
    else if (mul_done)     hi_d = acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
    end
  end
`else
  assign is_mul     = 1'b0;
  assign mul_done   = 1'b0;
  assign in_ready   = !reset && out_free;
  assign ALU_Out_Hi = '0;
`endif

  // A new load always wins over consumption, so simultaneous pop+push keeps out_valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      res_d       = s_res;
      carry_d     = s_carry;
      zero_d      = (s_res == '0);
      neg_d       = s_res[WIDTH-1];
      ovf_d       = s_ovf;
      err_d       = s_err;
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      res_d       = acc_q[WIDTH-1:0];
      carry_d     = 1'b0;
      zero_d      = (acc_q == '0);
      neg_d       = acc_q[2*WIDTH-1];
      ovf_d       = 1'b0;
      err_d       = 1'b0;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALU_Out   = res_q;
  assign CarryOut  = carry_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Overflow  = ovf_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed cases then randomized ops with random output backpressure.
module tb_alu_pipe;
  localparam int W = 8;
  localparam int M = 1 << W;
`ifdef ALU_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   in_op;
  logic [W-1:0] a_i, b_i, alu_out, alu_out_hi;
  logic         carry_out, zero, negative, overflow, err;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_rdy = 1'b0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .A(a_i), .B(b_i), .out_valid(out_valid), .out_ready(out_ready), .ALU_Out(alu_out),
    .ALU_Out_Hi(alu_out_hi), .CarryOut(carry_out), .Zero(zero), .Negative(negative),
    .Overflow(overflow), .Err(err)
  );

  // Reference model: integer arithmetic on the signed/unsigned views of the operands.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t         r;
    int           sa, sb, s;
    longint       p;
    logic [W-1:0] va, vb;
    r  = '0;
    va = W'(a);
    vb = W'(b);
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    case (op)
      0: begin s = a + b; r.lo = W'(s % M); r.c = (s >= M); r.v = (sa + sb > M / 2 - 1) || (sa + sb < -M / 2); end
      1: begin s = a - b; r.lo = W'((s + M) % M); r.c = (a < b); r.v = (sa - sb > M / 2 - 1) || (sa - sb < -M / 2); end
      2: r.lo = va & vb;
      3: r.lo = va | vb;
      4: r.lo = va ^ vb;
      5: r.lo = ~(va ^ vb);
      6: r.lo = ~(va & vb);
      7: r.lo = ~(va | vb);
      8: begin
        if (MULEN) begin
          p = longint'(a) * longint'(b);
          r.lo = W'(p % M);
          r.hi = W'(p / M);
        end else r.e = 1'b1;
      end
      default: r.e = 1'b1;
    endcase
    r.z = (r.lo == 0) && (r.hi == 0);
    r.n = (MULEN && op == 8) ? r.hi[W-1] : r.lo[W-1];
    return r;
  endfunction

  function automatic exp_t dut_vec();
    return {alu_out, alu_out_hi, carry_out, zero, negative, overflow, err};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Push side of the scoreboard, sampled mid-cycle after the monitor has taken its look.
  always @(negedge clk) begin
    #1;
    if (in_valid && in_ready) sb_q.push_back(model(int'(in_op), int'(a_i), int'(b_i)));
  end

  // Monitor: a result is consumed on the next edge whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected no result", dut_vec());
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", dut_vec(), e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input int a, input int b, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_op    = 4'(op);
    a_i      = W'(a);
    b_i      = W'(b);
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("issue_timeout", 64'(waits), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic int pick();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return M - 1;
      2:       return M / 2;
      default: return int'($urandom_range(0, M - 1));
    endcase
  endfunction

  initial begin
    int         w, cyc, n;
    bit         busy_ok, seen;
    exp_t       e;
    logic [7:0] seq [6];
    seq = '{8'h03, 8'h0F, 8'h0C, 8'hF3, 8'hFC, 8'hF0};

    reset = 1'b1; in_valid = 1'b0; in_op = '0; a_i = '0; b_i = '0; out_ready = 1'b0;
    repeat (3) step();
    check("reset_outputs", {out_valid, in_ready, dut_vec()}, 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    out_ready = 1'b1;

    issue(0, 'hFF, 'h01, w);
    check("add_ff_01", {out_valid, alu_out, carry_out, zero, overflow}, {1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
    issue(1, 'h80, 'h01, w);
    check("sub_80_01", {alu_out, overflow, carry_out}, {8'h7F, 1'b1, 1'b0});
    issue(1, 'h03, 'h0F, w);
    check("sub_03_0f", {alu_out, carry_out, negative}, {8'hF4, 1'b1, 1'b1});

    for (int i = 0; i < 6; i++) begin
      issue(i + 2, 'h0F, 'h03, w);
      check("b2b_value", alu_out, seq[i]);
      check("b2b_no_bubble", 64'(w), 0);
    end

    step();
    out_ready = 1'b0;
    issue(0, 'h12, 'h34, w);
    e = model(0, 'h12, 'h34);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {out_valid, dut_vec()}, {1'b1, e});
    end
    out_ready = 1'b1;
    issue(4, 'hA5, 'h3C, w);
    check("replace_no_wait", 64'(w), 0);
    check("replace_valid", out_valid, 1);
    e = model(4, 'hA5, 'h3C);
    check("replace_value", alu_out, e.lo);

    step();
    issue(8, 'hFF, 'hFF, w);
`ifdef ALU_MUL_EN
    cyc = 0;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 50) begin
      if (in_ready) busy_ok = 1'b0;
      step();
      cyc++;
    end
    check("mul_latency", 64'(cyc), W + 1);
    check("mul_busy", busy_ok, 1);
    check("mul_ff_ff", {alu_out_hi, alu_out}, 16'hFE01);
`else
    check("mul_illegal", {out_valid, err, zero}, 3'b111);
`endif

    step();
    issue(8, 'h5A, 'hC3, w);
    repeat (3) step();
    reset = 1'b1;
    sb_q.delete();
    step();
    check("midmul_reset", {out_valid, in_ready, dut_vec()}, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("midmul_no_result", seen, 0);
    issue(0, 'h01, 'h02, w);
    check("post_reset_add", alu_out, 8'h03);

    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      issue(op, pick(), pick(), w);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 8-bit registered ALU. It accepts one operation per transaction on a valid/ready input port and returns a registered result with full status flags on a valid/ready output port. The block supports the eight single-cycle arithmetic/logic ops and an optional multi-cycle unsigned multiplier. It sits between the datapath operand registers and the result writeback stage.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept this cycle
- in_op  input  4  operation select
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  consumer takes result this cycle
- ALU_Out  output  WIDTH  result; MUL low half
- ALU_Out_Hi  output  WIDTH  MUL high half, else 0
- CarryOut  output  1  carry (ADD) / borrow (SUB), else 0
- Zero  output  1  full result == 0 (MUL: all 2·WIDTH bits)
- Negative  output  1  MSB of ALU_Out (MUL: MSB of ALU_Out_Hi)
- Overflow  output  1  signed overflow for ADD/SUB, else 0
- Err  output  1  in_op was illegal

## Operation
- Op encoding: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 NAND, 7 NOR, 8 MUL (unsigned, only with ALU_MUL_EN), 9–15 illegal.
- Accept = in_valid && in_ready, sampled on the rising edge of clk.
- in_ready = !reset && state==IDLE && (!out_valid || out_ready).
- ADD: {CarryOut, ALU_Out} = A+B, computed at WIDTH+1 bits. SUB: ALU_Out = A−B mod 2^WIDTH; CarryOut=1 iff A<B unsigned. Overflow follows the two's-complement rule for the signed view of each.
- Logic ops: bitwise; CarryOut=Overflow=0.
- Illegal op: ALU_Out=ALU_Out_Hi=0, Err=1, Zero=1, other flags 0, latency 1.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: single-cycle op accepted → output registers loaded on the accept edge. MUL accepted → go to MUL, load multiplicand/multiplier, clear the 2·WIDTH accumulator, counter=0.
  - MUL: one shift-add iteration per cycle; when counter reaches WIDTH−1 → HOLD.
  - HOLD: load product into output registers when (!out_valid || out_ready), then → IDLE.
- Output registers hold all values stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new result is loaded in the same cycle. Back-to-back single-cycle throughput is one per clock.

## Timing
- Reset: all outputs 0 (ALU_Out, ALU_Out_Hi, flags, Err, out_valid); in_ready=0 while reset is high and 1 in the first cycle after it, state=IDLE, counter=0.
- Single-cycle ops: accept at edge N → out_valid=1 and result visible after edge N.
- MUL: accept at edge N → iterations on edges N+1..N+WIDTH → result loaded at edge N+WIDTH+1 if the output is free, later otherwise. in_ready=0 from N until return to IDLE.
- Simultaneous out_ready and accept: old result consumed and new result loaded on the same edge; out_valid stays 1.
- Reset mid-MUL: operation discarded, no result emitted, state returns to IDLE on that edge.
- Counter is ⌈log2(WIDTH)⌉+1 bits and never wraps within an operation.

## Configuration
- ALU_MUL_EN defined: op 8 is an unsigned WIDTH×WIDTH→2·WIDTH shift-add multiply, and the MUL/HOLD states and accumulator are present.
- ALU_MUL_EN undefined: op 8 is illegal (Err=1, latency 1). The FSM reduces to IDLE only, ALU_Out_Hi is tied 0, and in_ready = !reset && (!out_valid || out_ready).

## Test plan
- WIDTH=8, ADD A=0xFF B=0x01, out_ready=1 → next cycle ALU_Out=0x00, CarryOut=1, Zero=1, Overflow=0, out_valid=1.
- SUB A=0x80 B=0x01 → ALU_Out=0x7F, Overflow=1, CarryOut=0. SUB A=0x03 B=0x0F → ALU_Out=0xF4, CarryOut=1, Negative=1.
- Ops 2–7 with A=0x0F B=0x03 back-to-back, one per cycle → ALU_Out sequence 0x03, 0x0F, 0x0C, 0xF3, 0xFC, 0xF0; no bubbles.
- Backpressure: ADD accepted, out_ready=0 for 3 cycles → in_ready=0, ALU_Out stable. out_ready=1 together with a new XOR → result replaced on the same edge, out_valid stays 1.
- ALU_MUL_EN, MUL A=0xFF B=0xFF → out_valid rises 9 cycles after accept, ALU_Out_Hi=0xFE, ALU_Out=0x01, in_ready=0 throughout. Without the macro → Err=1 after 1 cycle.
- Reset asserted 4 cycles into MUL → all outputs 0, no result emitted; ADD 0x01+0x02 afterwards → 0x03.
